// File: rtl/window_vgauss_filter.sv
`default_nettype none
// ============================================================================
// Module   : window_vgauss_filter
// Brief    : Vertical Gaussian over a BLK_H-tall window column; emits a
//            valid-tagged pixel stream for windows fully inside the frame.
// Revision : 1.0
// ============================================================================
module window_vgauss_filter #(
    parameter int                      BLK_H   = 5,
    parameter int                      PIX_W   = 8,
    parameter int                      FRAME_W = 640,
    parameter int                      FRAME_H = 480,
    parameter int                      COEF_W  = 8,
    parameter logic [BLK_H*COEF_W-1:0] COEFS   = 40'h01_04_06_04_01,
    parameter int                      SHIFT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_en,
    input  logic                   in_sof,
    input  logic [BLK_H*PIX_W-1:0] win,
    output logic [PIX_W-1:0]       out_pix,
    output logic                   out_valid,
    output logic [9:0]             out_col,
    output logic                   out_eol,
    output logic                   out_eof
);

    localparam int c_PROD_W = PIX_W + COEF_W;
    localparam int c_SUM_W  = c_PROD_W + $clog2(BLK_H);
    localparam int c_RND_W  = c_SUM_W + 1;
    localparam int c_COL_W  = 10;
    localparam int c_ROW_W  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(FRAME_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(FRAME_H - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(BLK_H - 1);
    localparam logic [c_RND_W-1:0] c_HALF      =
        c_RND_W'((SHIFT > 0) ? 1 : 0) << ((SHIFT > 0) ? SHIFT - 1 : 0);
    localparam logic [c_RND_W-1:0] c_PIX_MAX   = c_RND_W'({PIX_W{1'b1}});

    logic [c_COL_W-1:0]  r_col, r_tagCol, w_posCol, w_nextCol;
    logic [c_ROW_W-1:0]  r_row, r_tagRow, w_posRow, w_nextRow;
    logic                r_enD1;
    logic                w_s0Valid, w_s0Eol, w_s0Eof;
    logic [c_PROD_W-1:0] r_prod [BLK_H];
    logic [c_SUM_W-1:0]  w_sum, r_sum;
    logic [c_RND_W-1:0]  w_rnd;
    logic [PIX_W-1:0]    w_sat;
    logic                r_v1, r_v2, r_eol1, r_eol2, r_eof1, r_eof2;
    logic [c_COL_W-1:0]  r_col1, r_col2;

    // A start-of-frame pixel is (0,0) regardless of where the counters stood.
    always_comb begin
        w_posCol  = in_sof ? '0 : r_col;
        w_posRow  = in_sof ? '0 : r_row;
        w_nextCol = w_posCol + c_COL_W'(1);
        w_nextRow = w_posRow;
        if (w_posCol == c_COL_LAST) begin
            w_nextCol = '0;
            w_nextRow = (w_posRow == c_ROW_LAST) ? '0 : w_posRow + c_ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_enD1   <= 1'b0;
            r_tagCol <= '0;
            r_tagRow <= '0;
        end else begin
            r_enD1 <= in_en;
            if (in_en) begin
                r_col    <= w_nextCol;
                r_row    <= w_nextRow;
                r_tagCol <= w_posCol;
                r_tagRow <= w_posRow;
            end
        end
    end

    assign w_s0Valid = r_enD1 && (r_tagRow >= c_ROW_FIRST);
    assign w_s0Eol   = (r_tagCol == c_COL_LAST);
    assign w_s0Eof   = w_s0Eol && (r_tagRow == c_ROW_LAST);

    // Datapath runs unconditionally; only the valid bits decide what is emitted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BLK_H; i++) begin
            r_prod[i] <= c_PROD_W'(win[i*PIX_W +: PIX_W]) *
                         c_PROD_W'(COEFS[i*COEF_W +: COEF_W]);
        end
        r_sum <= w_sum;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < BLK_H; i++) begin
            w_sum = w_sum + c_SUM_W'(r_prod[i]);
        end
    end

    // One guard bit keeps the rounding add from wrapping.
    assign w_rnd = ({1'b0, r_sum} + c_HALF) >> SHIFT;
    assign w_sat = (w_rnd > c_PIX_MAX) ? '1 : w_rnd[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_eol1    <= 1'b0;
            r_eol2    <= 1'b0;
            r_eof1    <= 1'b0;
            r_eof2    <= 1'b0;
            r_col1    <= '0;
            r_col2    <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            out_col   <= '0;
            out_pix   <= '0;
        end else begin
            r_v1      <= w_s0Valid;
            r_eol1    <= w_s0Eol;
            r_eof1    <= w_s0Eof;
            r_col1    <= r_tagCol;
            r_v2      <= r_v1;
            r_eol2    <= r_eol1;
            r_eof2    <= r_eof1;
            r_col2    <= r_col1;
            out_valid <= r_v2;
            out_eol   <= r_v2 && r_eol2;
            out_eof   <= r_v2 && r_eof2;
            if (r_v2) begin
                out_col <= r_col2;
                out_pix <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_vgauss_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_vgauss_filter
// Brief    : Directed bench for window_vgauss_filter on a reduced 16x12 frame.
// Revision : 1.0
// ============================================================================
module tb_window_vgauss_filter;

    localparam int c_W  = 16;
    localparam int c_H  = 12;
    localparam int c_NT = 5;

    localparam int K_CONST = 0;
    localparam int K_IMP   = 1;
    localparam int K_RND   = 2;
    localparam int K_SAT   = 3;
    localparam int K_RAND  = 4;

    typedef struct {
        int t; int kind; int row; int col;
        int pm; int pr; int ps; int eol; int eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_en = 1'b0;
    logic        in_sof = 1'b0;
    logic [39:0] win = '0;
    logic [7:0]  pixM, pixR, pixS;
    logic        valM, valR, valS, eolM, eolR, eolS, eofM, eofR, eofS;
    logic [9:0]  colM, colR, colS;

    int   cyc = 0;
    bit   rstSeen = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e;
    logic [39:0] pendWin = '0;
    int   holdM = 0, holdR = 0, holdS = 0;
    int   cntV = 0, cntEol = 0, cntEof = 0;
    int   capImpM[5], capImpR[5], capRnd[2], capSatM, capSatS;
    int   coefM[c_NT] = '{1, 4, 6, 4, 1};
    int   coefR[c_NT] = '{1, 1, 1, 1, 1};
    int   coefS[c_NT] = '{8, 8, 8, 8, 8};

    window_vgauss_filter #(.FRAME_W(c_W), .FRAME_H(c_H)) dutM (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_sof(in_sof), .win(win),
        .out_pix(pixM), .out_valid(valM), .out_col(colM), .out_eol(eolM), .out_eof(eofM));
    window_vgauss_filter #(.FRAME_W(c_W), .FRAME_H(c_H), .COEFS(40'h01_01_01_01_01)) dutR (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_sof(in_sof), .win(win),
        .out_pix(pixR), .out_valid(valR), .out_col(colR), .out_eol(eolR), .out_eof(eofR));
    window_vgauss_filter #(.FRAME_W(c_W), .FRAME_H(c_H), .COEFS(40'h08_08_08_08_08)) dutS (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_sof(in_sof), .win(win),
        .out_pix(pixS), .out_valid(valS), .out_col(colS), .out_eol(eolS), .out_eof(eofS));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rstSeen <= !rst_n;
    end

    function automatic int pixVal(input int kind, input int r, input int c);
        if (r < 0) return (c * 29 - r * 53 + 7) & 255;
        case (kind)
            K_CONST: return 100;
            K_IMP:   return (r == 6 && c == 5) ? 160 : 0;
            K_RND:   return (c == 0) ? ((r % 5 == 0) ? 8 : 4) :
                            (c == 1) ? ((r % 5 == 0) ? 7 : 4) : ((r * 7 + c * 3) & 63);
            K_SAT:   return 255;
            default: return (r * 37 + c * 91 + r * c * 13 + 11) & 255;
        endcase
    endfunction

    // Vertical filter of the column ending at row r: rows r, r-1, ... weighted by taps 0, 1, ...
    function automatic int model(input int co[c_NT], input int kind, input int r, input int c);
        int sum = 0;
        int res;
        for (int i = 0; i < c_NT; i++) sum += co[i] * pixVal(kind, r - i, c);
        res = (sum + 8) / 16;
        return (res > 255) ? 255 : res;
    endfunction

    function automatic logic [39:0] column(input int kind, input int r, input int c);
        logic [39:0] w;
        for (int i = 0; i < c_NT; i++) w[i*8 +: 8] = 8'(pixVal(kind, r - i, c));
        return w;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step(input bit en, input bit sof, input int kind, input int r, input int c);
        exp_t x;
        in_en  = en;
        in_sof = sof;
        win    = pendWin;
        if (en) begin
            pendWin = column(kind, r, c);
            if (r >= c_NT - 1) begin
                x.t = cyc + 4; x.kind = kind; x.row = r; x.col = c;
                x.pm = model(coefM, kind, r, c);
                x.pr = model(coefR, kind, r, c);
                x.ps = model(coefS, kind, r, c);
                x.eol = (c == c_W - 1) ? 1 : 0;
                x.eof = (c == c_W - 1 && r == c_H - 1) ? 1 : 0;
                q.push_back(x);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    // gap idle cycles after every pixel; a stray in_sof rides on some gaps without in_en
    task automatic sendFrame(input int kind, input int nRows, input int gap);
        for (int r = 0; r < nRows; r++) begin
            for (int c = 0; c < c_W; c++) begin
                step(1'b1, (r == 0 && c == 0), kind, r, c);
                for (int g = 0; g < gap; g++) step(1'b0, (g == 0 && c == 3), kind, r, c);
            end
        end
    endtask

    task automatic checkCounts(input string name, input int v0, input int l0, input int f0,
                               input int v, input int l, input int f);
        chk({name, "_valid_count"}, cntV - v0, v);
        chk({name, "_eol_count"}, cntEol - l0, l);
        chk({name, "_eof_count"}, cntEof - f0, f);
    endtask

    always @(negedge clk) begin
        if (valM) cntV++;
        if (eolM) cntEol++;
        if (eofM) cntEof++;
        if (rstSeen) begin
            q.delete();
            holdM = 0; holdR = 0; holdS = 0;
            chk("rst_valid", {valM, valR, valS}, 0);
            chk("rst_pix", {pixM, pixR, pixS}, 0);
            chk("rst_col", colM, 0);
            chk("rst_eol_eof", {eolM, eofM}, 0);
        end else if (q.size() > 0 && q[0].t == cyc) begin
            e = q.pop_front();
            chk("out_valid", {valM, valR, valS}, 7);
            chk("pix_main", pixM, e.pm);
            chk("pix_round", pixR, e.pr);
            chk("pix_sat", pixS, e.ps);
            chk("out_col", colM, e.col);
            chk("out_eol", eolM, e.eol);
            chk("out_eof", eofM, e.eof);
            holdM = e.pm; holdR = e.pr; holdS = e.ps;
            if (e.kind == K_IMP && e.col == 5 && e.row >= 6 && e.row <= 10) begin
                capImpM[e.row-6] = pixM;
                capImpR[e.row-6] = pixR;
            end
            if (e.kind == K_RND && e.row == 8 && e.col < 2) capRnd[e.col] = pixR;
            if (e.kind == K_SAT && e.row == c_H - 1 && e.col == c_W - 1) begin
                capSatM = pixM;
                capSatS = pixS;
            end
        end else begin
            chk("idle_valid", {valM, valR, valS}, 0);
            chk("idle_eol_eof", {eolM, eofM}, 0);
            chk("hold_main", pixM, holdM);
            chk("hold_round", pixR, holdR);
            chk("hold_sat", pixS, holdS);
        end
    end

    initial begin
        int v0, l0, f0;
        int impExp[5] = '{10, 40, 60, 40, 10};
        for (int i = 0; i < 5; i++) begin capImpM[i] = -1; capImpR[i] = -1; end
        capRnd[0] = -1; capRnd[1] = -1; capSatM = -1; capSatS = -1;

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(3);

        v0 = cntV; l0 = cntEol; f0 = cntEof;
        sendFrame(K_CONST, c_H, 0);
        idle(6);
        checkCounts("const", v0, l0, f0, (c_H - 4) * c_W, c_H - 4, 1);

        sendFrame(K_IMP, c_H, 0);
        idle(6);
        for (int i = 0; i < 5; i++) begin
            chk("impulse_main", capImpM[i], impExp[i]);
            chk("impulse_flat", capImpR[i], 10);
        end

        sendFrame(K_RND, c_H, 0);
        idle(6);
        chk("round_sum24", capRnd[0], 2);
        chk("round_sum23", capRnd[1], 1);

        sendFrame(K_SAT, c_H, 0);
        idle(6);
        chk("sat_clip", capSatS, 255);
        chk("sat_main", capSatM, 255);

        v0 = cntV; l0 = cntEol; f0 = cntEof;
        sendFrame(K_RAND, c_H, 2);
        idle(6);
        checkCounts("gapped", v0, l0, f0, (c_H - 4) * c_W, c_H - 4, 1);

        v0 = cntV; l0 = cntEol; f0 = cntEof;
        sendFrame(K_RAND, 8, 0);
        sendFrame(K_RAND, c_H, 0);
        idle(6);
        checkCounts("resync", v0, l0, f0, 4 * c_W + (c_H - 4) * c_W, 4 + c_H - 4, 1);

        sendFrame(K_RAND, 6, 0);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, K_RAND, 6, c);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        v0 = cntV; l0 = cntEol; f0 = cntEof;
        sendFrame(K_CONST, c_H, 0);
        idle(6);
        checkCounts("post_reset", v0, l0, f0, (c_H - 4) * c_W, c_H - 4, 1);

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
